apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_wait_timer.sv | 37 +++
 rtl/apb_cmd_master.sv | 145 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the command-master state encoding.
package apb_pkg;

   localparam int unsigned APB_ADDR_WIDTH  = 7;
   localparam int unsigned APB_DATA_WIDTH  = 32;
   localparam int unsigned APB_STATE_WIDTH = 2;

   localparam logic [APB_STATE_WIDTH-1:0] ST_IDLE   = 2'd0;
   localparam logic [APB_STATE_WIDTH-1:0] ST_SETUP  = 2'd1;
   localparam logic [APB_STATE_WIDTH-1:0] ST_ACCESS = 2'd2;
   localparam logic [APB_STATE_WIDTH-1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expired_c flags the cycle in which the count reaches LIMIT.
module apb_wait_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // This wait cycle would be the LIMIT-th one
   assign expired_c = enable && (cnt_q == CNT_W'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired_c) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_cmd_master.sv
// Converts single valid/ready commands into APB transfers, one outstanding at a time,
// with a bounded wait on PREADY and a held response until consumed.
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic                  i_cmd_write,
   input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic [ADDR_WIDTH-1:0] o_PADDR,
   output logic                  o_PWRITE,
   output logic                  o_PSEL,
   output logic                  o_PENABLE,
   output logic [DATA_WIDTH-1:0] o_PWDATA,
   input  logic                  i_PREADY,
   input  logic [DATA_WIDTH-1:0] i_PRDATA,
   input  logic                  i_PSLVERR
);

   logic [APB_STATE_WIDTH-1:0] state_q, state_d;
   logic                       cmd_ready_q, cmd_ready_d;
   logic                       psel_q, psel_d;
   logic                       penable_q, penable_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic [ADDR_WIDTH-1:0]      paddr_q, paddr_d;
   logic                       pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
   logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
   logic                       rsp_err_q, rsp_err_d;

   logic                       wait_clear;
   logic                       wait_enable;
   logic                       wait_expired_c;

   assign wait_clear  = (state_q != ST_ACCESS);
   assign wait_enable = (state_q == ST_ACCESS) && !i_PREADY;

   apb_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .clear     (wait_clear),
      .enable    (wait_enable),
      .expired_c (wait_expired_c)
   );

   // Next state and payload; the registered controls decode the next state so they
   // line up with the state they describe.
   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_ready_q && i_cmd_valid) begin
               state_d  = ST_SETUP;
               paddr_d  = i_cmd_addr;
               pwrite_d = i_cmd_write;
               pwdata_d = i_cmd_wdata;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // Completer response wins over a timeout landing in the same cycle
            if (i_PREADY) begin
               state_d     = ST_RESP;
               rsp_rdata_d = pwrite_q ? '0 : i_PRDATA;
               rsp_err_d   = i_PSLVERR;
            end else if (wait_expired_c) begin
               state_d     = ST_RESP;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
            end
         end
         ST_RESP: begin
            if (i_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_d   = (state_d == ST_ACCESS);
      rsp_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign o_cmd_ready = cmd_ready_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_PADDR     = paddr_q;
   assign o_PWRITE    = pwrite_q;
   assign o_PSEL      = psel_q;
   assign o_PENABLE   = penable_q;
   assign o_PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed vector table, reset corners, then random commands
// against a transaction-level model, with a behavioural APB memory completer.
module tb_apb_cmd_master;

   localparam int unsigned AW    = 7;
   localparam int unsigned DW    = 32;
   localparam int          TO    = 16;
   localparam int          NEVER = 99;
   localparam logic [DW-1:0] BAD = 32'h0BAD_0BAD;
   localparam logic [AW-1:0] ERR_ADDR = 7'h7F;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_cmd_valid = 1'b0;
   logic          o_cmd_ready;
   logic          i_cmd_write = 1'b0;
   logic [AW-1:0] i_cmd_addr = '0;
   logic [DW-1:0] i_cmd_wdata = '0;
   logic          o_rsp_valid;
   logic          i_rsp_ready = 1'b0;
   logic [DW-1:0] o_rsp_rdata;
   logic          o_rsp_err;
   logic [AW-1:0] o_PADDR;
   logic          o_PWRITE;
   logic          o_PSEL;
   logic          o_PENABLE;
   logic [DW-1:0] o_PWDATA;
   logic          i_PREADY = 1'b0;
   logic [DW-1:0] i_PRDATA = '0;
   logic          i_PSLVERR = 1'b0;

   always #5 clk = ~clk;

   apb_cmd_master #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_write (i_cmd_write),
      .i_cmd_addr  (i_cmd_addr),
      .i_cmd_wdata (i_cmd_wdata),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_rdata (o_rsp_rdata),
      .o_rsp_err   (o_rsp_err),
      .o_PADDR     (o_PADDR),
      .o_PWRITE    (o_PWRITE),
      .o_PSEL      (o_PSEL),
      .o_PENABLE   (o_PENABLE),
      .o_PWDATA    (o_PWDATA),
      .i_PREADY    (i_PREADY),
      .i_PRDATA    (i_PRDATA),
      .i_PSLVERR   (i_PSLVERR)
   );

   int errors = 0;
   int checks = 0;
   int acc = 0;
   logic [DW-1:0] slave_mem [128];
   logic [DW-1:0] model_mem [128];

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            waits;
      int            rdelay;
      logic          exp_err;
      logic [DW-1:0] exp_rdata;
      int            exp_lat;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // APB memory completer: PREADY after 'waits' low ACCESS cycles, error at ERR_ADDR
   task automatic slave_step(input int waits);
      logic rdy;
      if (o_PSEL && o_PENABLE) begin
         acc++;
         rdy = (waits != NEVER) && (acc == waits + 1);
         i_PREADY  = rdy;
         i_PSLVERR = rdy ? (o_PADDR == ERR_ADDR) : 1'($urandom);
         if (rdy && !o_PWRITE)
            i_PRDATA = (o_PADDR == ERR_ADDR) ? BAD : slave_mem[o_PADDR];
         else
            i_PRDATA = $urandom;
         if (rdy && o_PWRITE && (o_PADDR != ERR_ADDR))
            slave_mem[o_PADDR] = o_PWDATA;
      end else begin
         acc       = 0;
         i_PREADY  = 1'b0;
         i_PSLVERR = 1'b0;
         i_PRDATA  = $urandom;
      end
   endtask

   // Transaction-level expectation: latency counted from the accept edge to rsp_valid
   task automatic model(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, output logic err, output logic [DW-1:0] rdata,
                        output int lat);
      logic to;
      to    = (waits >= TO);
      lat   = 2 + (to ? TO : waits + 1);
      err   = to || (addr == ERR_ADDR);
      rdata = (wr || to) ? '0 : ((addr == ERR_ADDR) ? BAD : model_mem[addr]);
      if (wr && !err) model_mem[addr] = wdata;
   endtask

   task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int waits, input int rdelay, input logic exp_err,
                          input logic [DW-1:0] exp_rdata, input int exp_lat);
      int n;
      int guard;
      i_cmd_valid = 1'b1;
      i_cmd_write = wr;
      i_cmd_addr  = addr;
      i_cmd_wdata = wdata;
      guard = 0;
      while (!o_cmd_ready && guard < 20) begin
         slave_step(waits);
         tick();
         guard++;
      end
      check("cmd_ready_before_accept", 32'(o_cmd_ready), 32'd1);
      tick();
      // Scramble the command bus; the in-flight transfer must not see it
      i_cmd_valid = 1'b0;
      i_cmd_write = 1'($urandom);
      i_cmd_addr  = AW'($urandom);
      i_cmd_wdata = $urandom;
      n = 1;
      while (n <= 40) begin
         if (o_rsp_valid) break;
         check(n == 1 ? "setup_psel" : "access_psel", 32'(o_PSEL), 32'd1);
         check(n == 1 ? "setup_penable" : "access_penable", 32'(o_PENABLE), n == 1 ? 32'd0 : 32'd1);
         check("paddr", 32'(o_PADDR), 32'(addr));
         check("pwrite", 32'(o_PWRITE), 32'(wr));
         check("pwdata", o_PWDATA, wdata);
         check("cmd_ready_busy", 32'(o_cmd_ready), 32'd0);
         slave_step(waits);
         tick();
         n++;
      end
      check("latency", 32'(n), 32'(exp_lat));
      check("rsp_err", 32'(o_rsp_err), 32'(exp_err));
      check("rsp_rdata", o_rsp_rdata, exp_rdata);
      check("resp_psel", 32'(o_PSEL), 32'd0);
      check("resp_penable", 32'(o_PENABLE), 32'd0);
      slave_step(waits);
      for (int d = 0; d < rdelay; d++) begin
         i_rsp_ready = 1'b0;
         tick();
         slave_step(waits);
         check("rsp_valid_held", 32'(o_rsp_valid), 32'd1);
         check("rsp_err_held", 32'(o_rsp_err), 32'(exp_err));
         check("rsp_rdata_held", o_rsp_rdata, exp_rdata);
         check("cmd_ready_in_resp", 32'(o_cmd_ready), 32'd0);
      end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      slave_step(waits);
      check("rsp_valid_cleared", 32'(o_rsp_valid), 32'd0);
      check("cmd_ready_after_rsp", 32'(o_cmd_ready), 32'd1);
      check("paddr_hold_idle", 32'(o_PADDR), 32'(addr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          e_err;
      logic [DW-1:0] e_rdata;
      int            e_lat;
      logic          wr;
      logic [AW-1:0] addr;
      int            r;
      int            w;

      vecs[0] = '{1'b1, 7'h05, 32'hDEADBEEF, 0,     0, 1'b0, 32'h0,        3};
      vecs[1] = '{1'b0, 7'h05, 32'h0,        0,     0, 1'b0, 32'hDEADBEEF, 3};
      vecs[2] = '{1'b0, 7'h05, 32'h0,        3,     1, 1'b0, 32'hDEADBEEF, 6};
      vecs[3] = '{1'b0, 7'h05, 32'h0,        NEVER, 0, 1'b1, 32'h0,        18};
      vecs[4] = '{1'b0, 7'h7F, 32'h0,        0,     5, 1'b1, BAD,          3};
      vecs[5] = '{1'b1, 7'h10, 32'hCAFEF00D, 15,    0, 1'b0, 32'h0,        18};
      vecs[6] = '{1'b0, 7'h10, 32'h0,        0,     2, 1'b0, 32'hCAFEF00D, 3};
      vecs[7] = '{1'b1, 7'h11, 32'h12345678, 16,    0, 1'b1, 32'h0,        18};
      vecs[8] = '{1'b0, 7'h11, 32'h0,        1,     0, 1'b0, 32'h0,        4};
      vecs[9] = '{1'b1, 7'h7F, 32'h55AA55AA, 0,     0, 1'b1, 32'h0,        3};

      for (int i = 0; i < 128; i++) begin
         slave_mem[i] = '0;
         model_mem[i] = '0;
      end

      // Reset state
      #12;
      check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
      check("rst_psel", 32'(o_PSEL), 32'd0);
      check("rst_penable", 32'(o_PENABLE), 32'd0);
      check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(o_rsp_err), 32'd0);
      check("rst_rsp_rdata", o_rsp_rdata, 32'd0);
      check("rst_paddr", 32'(o_PADDR), 32'd0);
      check("rst_pwdata", o_PWDATA, 32'd0);
      tick();
      rst_n = 1'b1;
      check("cmd_ready_at_release", 32'(o_cmd_ready), 32'd0);
      tick();
      check("cmd_ready_one_edge_after_release", 32'(o_cmd_ready), 32'd1);

      // Directed table
      foreach (vecs[i]) begin
         run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].rdelay,
                 vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat);
         model(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, e_err, e_rdata, e_lat);
      end

      // Reset during ACCESS aborts with no response
      i_cmd_valid = 1'b1;
      i_cmd_write = 1'b1;
      i_cmd_addr  = 7'h20;
      i_cmd_wdata = 32'hA5A5A5A5;
      tick();
      i_cmd_valid = 1'b0;
      slave_step(NEVER);
      tick();
      slave_step(NEVER);
      tick();
      check("pre_reset_access_penable", 32'(o_PENABLE), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_psel", 32'(o_PSEL), 32'd0);
      check("abort_penable", 32'(o_PENABLE), 32'd0);
      check("abort_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("abort_cmd_ready", 32'(o_cmd_ready), 32'd0);
      slave_step(NEVER);
      tick();
      rst_n = 1'b1;
      check("abort_cmd_ready_release", 32'(o_cmd_ready), 32'd0);
      tick();
      check("abort_cmd_ready_after", 32'(o_cmd_ready), 32'd1);
      check("abort_no_rsp", 32'(o_rsp_valid), 32'd0);
      // Timer must restart from zero: 15 waits still completes
      model(1'b0, 7'h10, 32'h0, 15, e_err, e_rdata, e_lat);
      run_txn(1'b0, 7'h10, 32'h0, 15, 0, e_err, e_rdata, e_lat);

      // Random commands against the model
      for (int t = 0; t < 40; t++) begin
         wr   = 1'($urandom_range(0, 1));
         r    = int'($urandom_range(0, 9));
         addr = (r == 9) ? ERR_ADDR : AW'(r);
         r    = int'($urandom_range(0, 9));
         if (r < 6)      w = int'($urandom_range(0, 3));
         else if (r < 8) w = int'($urandom_range(4, 15));
         else            w = int'($urandom_range(16, 20));
         i_cmd_wdata = $urandom;
         model(wr, addr, i_cmd_wdata, w, e_err, e_rdata, e_lat);
         run_txn(wr, addr, i_cmd_wdata, w, int'($urandom_range(0, 3)), e_err, e_rdata, e_lat);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
